reg_write_buffer: RTL and testbench

Pending-write queue between the writeback sources and the 8×32 register file's single write port. Up to DEPTH register writes are accepted from the writeback stage and drained one per cycle into the register file whenever its write port is free. Two read-side bypass ports let decode see the youngest pending value for any register still in flight. It is the writer-side partner of the register file: it produces RegWrite/WriteReg/WriteData and observes the same ReadReg1/ReadReg2 addresses.

---
 rtl/reg_write_buffer_pkg.sv | 16 +
 rtl/reg_write_buffer_if.sv | 40 ++++
 rtl/reg_write_buffer_wb_bypass_match.sv | 31 +++
 rtl/reg_write_buffer.sv | 80 ++++++++
 tb/tb_reg_write_buffer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_buffer_pkg.sv
// Shared register-file constants and the pending-write entry layout.
// Used by the write buffer, its bypass matcher and the register file itself.
package reg_write_buffer_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] regIdx;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/reg_write_buffer_if.sv
// Writeback-in / register-file-out / decode-bypass signal bundle of the write buffer.
// master = surrounding pipeline, slave = the buffer.
interface reg_write_buffer_if
    import reg_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              InValid;
    logic              InReady;
    logic [ADDR_W-1:0] InReg;
    logic [DATA_W-1:0] InData;
    logic              DrainEn;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic              Hit1;
    logic              Hit2;
    logic [DATA_W-1:0] FwdData1;
    logic [DATA_W-1:0] FwdData2;
    logic [CNT_W-1:0]  Count;
    logic              Empty;
    logic              Full;

    modport master (
        output InValid, InReg, InData, DrainEn, ReadReg1, ReadReg2,
        input  InReady, RegWrite, WriteReg, WriteData,
        input  Hit1, Hit2, FwdData1, FwdData2, Count, Empty, Full
    );

    modport slave (
        input  InValid, InReg, InData, DrainEn, ReadReg1, ReadReg2,
        output InReady, RegWrite, WriteReg, WriteData,
        output Hit1, Hit2, FwdData1, FwdData2, Count, Empty, Full
    );

endinterface

// File: rtl/reg_write_buffer_wb_bypass_match.sv
// Finds the youngest valid pending entry targeting readReg; combinational.
// Register zero never hits.
module wb_bypass_match
    import reg_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  entry_t                     entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [ADDR_W-1:0]          readReg,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);
    localparam int PTR_W = $clog2(DEPTH);

    // Walk oldest to youngest from the head so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx  = '0;
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (entries[idx].valid && (entries[idx].regIdx == readReg) && (readReg != REG_ZERO)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_write_buffer.sv
// Circular pending-write queue feeding the register-file write port, with two decode bypass ports.
// Push-to-drain one cycle; InReady drops only when full, writes to r0 are accepted and dropped.
module reg_write_buffer
    import reg_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    reg_write_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t            entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic empty;
    logic full;
    logic doPush;
    logic doPop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign doPush = bus.InValid && !full && (bus.InReg != REG_ZERO);
    assign doPop  = !empty && bus.DrainEn;

    assign bus.InReady   = !full;
    assign bus.Empty     = empty;
    assign bus.Full      = full;
    assign bus.Count     = count;
    assign bus.RegWrite  = doPop;
    assign bus.WriteReg  = empty ? '0 : entries[head].regIdx;
    assign bus.WriteData = empty ? '0 : entries[head].data;

    // Push never lands on the head slot while a pop is possible, since push is blocked when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                entries[k] <= '0;
            end
        end else begin
            if (doPush) begin
                entries[tail] <= '{valid: 1'b1, regIdx: bus.InReg, data: bus.InData};
                tail          <= tail + PTR_W'(1);
            end
            if (doPop) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH)) uMatch1 (
        .entries (entries),
        .head    (head),
        .readReg (bus.ReadReg1),
        .hit     (bus.Hit1),
        .data    (bus.FwdData1)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) uMatch2 (
        .entries (entries),
        .head    (head),
        .readReg (bus.ReadReg2),
        .hit     (bus.Hit2),
        .data    (bus.FwdData2)
    );

endmodule

// File: tb/tb_reg_write_buffer.sv
// Self-checking bench for reg_write_buffer: directed vector table, corner sequences, random vs queue model.
module tb_reg_write_buffer;
    import reg_write_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_write_buffer_if #(.DEPTH(DEPTH)) bus ();

    reg_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } mEnt_t;
    mEnt_t mq[$];

    logic              inVld;
    logic [ADDR_W-1:0] inReg;
    logic [DATA_W-1:0] inDat;
    logic              drn;
    logic [ADDR_W-1:0] rr1;
    logic [ADDR_W-1:0] rr2;

    typedef struct {
        logic        v;
        logic [2:0]  r;
        logic [31:0] d;
        logic        de;
        logic [2:0]  r1;
        logic [2:0]  r2;
        int          cnt;
        logic        rdy;
        logic        rw;
        logic [2:0]  wr;
        logic [31:0] wd;
        logic        h1;
        logic [31:0] f1;
        logic        h2;
        logic [31:0] f2;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic [2:0] r, input logic [31:0] d,
                         input logic de, input logic [2:0] a1, input logic [2:0] a2);
        inVld = v; inReg = r; inDat = d; drn = de; rr1 = a1; rr2 = a2;
        bus.InValid  = v;
        bus.InReg    = r;
        bus.InData   = d;
        bus.DrainEn  = de;
        bus.ReadReg1 = a1;
        bus.ReadReg2 = a2;
    endtask

    function automatic void lookup(input logic [2:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (a != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].r == a) begin
                    h = 1'b1;
                    d = mq[i].d;
                    break;
                end
            end
        end
    endfunction

    task automatic checkModel(input string tag);
        logic        h;
        logic [31:0] d;
        int          n;
        n = mq.size();
        chk({tag, "_count"}, 32'(bus.Count), 32'(n));
        chk({tag, "_empty"}, 32'(bus.Empty), 32'(n == 0));
        chk({tag, "_full"},  32'(bus.Full),  32'(n == DEPTH));
        chk({tag, "_ready"}, 32'(bus.InReady), 32'(n != DEPTH));
        chk({tag, "_regwr"}, 32'(bus.RegWrite), 32'((n > 0) && drn));
        chk({tag, "_wreg"},  32'(bus.WriteReg), (n > 0) ? 32'(mq[0].r) : 32'h0);
        chk({tag, "_wdata"}, bus.WriteData, (n > 0) ? mq[0].d : 32'h0);
        lookup(rr1, h, d);
        chk({tag, "_hit1"}, 32'(bus.Hit1), 32'(h));
        chk({tag, "_fwd1"}, bus.FwdData1, d);
        lookup(rr2, h, d);
        chk({tag, "_hit2"}, 32'(bus.Hit2), 32'(h));
        chk({tag, "_fwd2"}, bus.FwdData2, d);
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic commit();
        logic pop;
        logic push;
        pop  = (mq.size() > 0) && drn;
        push = inVld && (mq.size() != DEPTH) && (inReg != 0);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{r: inReg, d: inDat});
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    initial begin
        logic [2:0] prevReg;
        logic [31:0] prevDat;

        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_count", 32'(bus.Count), 0);
        chk("rst_ready", 32'(bus.InReady), 1);
        chk("rst_empty", 32'(bus.Empty), 1);
        chk("rst_full", 32'(bus.Full), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 3, 5);
        #1;
        chk("idle_regwr", 32'(bus.RegWrite), 0);
        chk("idle_wreg", 32'(bus.WriteReg), 0);
        chk("idle_wdata", bus.WriteData, 0);
        chk("idle_hit1", 32'(bus.Hit1), 0);
        chk("idle_hit2", 32'(bus.Hit2), 0);
        chk("idle_fwd1", bus.FwdData1, 0);
        chk("idle_fwd2", bus.FwdData2, 0);
        @(posedge clk);
        #1;

        tbl[0]  = '{1, 1, 32'h11,   0, 1, 0, 0, 1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0};
        tbl[1]  = '{1, 2, 32'h22,   0, 1, 0, 1, 1, 0, 1, 32'h11,   1, 32'h11,   0, 32'h0};
        tbl[2]  = '{1, 3, 32'h33,   0, 2, 0, 2, 1, 0, 1, 32'h11,   1, 32'h22,   0, 32'h0};
        tbl[3]  = '{1, 4, 32'h44,   0, 3, 1, 3, 1, 0, 1, 32'h11,   1, 32'h33,   1, 32'h11};
        tbl[4]  = '{1, 5, 32'h55,   0, 4, 0, 4, 0, 0, 1, 32'h11,   1, 32'h44,   0, 32'h0};
        tbl[5]  = '{0, 0, 32'h0,    1, 1, 0, 4, 0, 1, 1, 32'h11,   1, 32'h11,   0, 32'h0};
        tbl[6]  = '{0, 0, 32'h0,    1, 5, 0, 3, 1, 1, 2, 32'h22,   0, 32'h0,    0, 32'h0};
        tbl[7]  = '{0, 0, 32'h0,    1, 2, 0, 2, 1, 1, 3, 32'h33,   0, 32'h0,    0, 32'h0};
        tbl[8]  = '{0, 0, 32'h0,    1, 4, 0, 1, 1, 1, 4, 32'h44,   1, 32'h44,   0, 32'h0};
        tbl[9]  = '{1, 5, 32'hAAAA, 1, 5, 0, 0, 1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0};
        tbl[10] = '{1, 5, 32'hBBBB, 0, 5, 0, 1, 1, 0, 5, 32'hAAAA, 1, 32'hAAAA, 0, 32'h0};
        tbl[11] = '{0, 0, 32'h0,    1, 5, 0, 2, 1, 1, 5, 32'hAAAA, 1, 32'hBBBB, 0, 32'h0};
        tbl[12] = '{1, 0, 32'hDEAD, 0, 5, 0, 1, 1, 0, 5, 32'hBBBB, 1, 32'hBBBB, 0, 32'h0};
        tbl[13] = '{0, 0, 32'h0,    1, 5, 0, 1, 1, 1, 5, 32'hBBBB, 1, 32'hBBBB, 0, 32'h0};
        tbl[14] = '{0, 0, 32'h0,    0, 0, 0, 0, 1, 0, 0, 32'h0,    0, 32'h0,    0, 32'h0};

        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].de, tbl[i].r1, tbl[i].r2);
            #1;
            chk({t, "_count"}, 32'(bus.Count), 32'(tbl[i].cnt));
            chk({t, "_full"},  32'(bus.Full), 32'(tbl[i].cnt == DEPTH));
            chk({t, "_ready"}, 32'(bus.InReady), 32'(tbl[i].rdy));
            chk({t, "_regwr"}, 32'(bus.RegWrite), 32'(tbl[i].rw));
            chk({t, "_wreg"},  32'(bus.WriteReg), 32'(tbl[i].wr));
            chk({t, "_wdata"}, bus.WriteData, tbl[i].wd);
            chk({t, "_hit1"},  32'(bus.Hit1), 32'(tbl[i].h1));
            chk({t, "_fwd1"},  bus.FwdData1, tbl[i].f1);
            chk({t, "_hit2"},  32'(bus.Hit2), 32'(tbl[i].h2));
            chk({t, "_fwd2"},  bus.FwdData2, tbl[i].f2);
            tick();
        end

        // Streaming: one push and one drain per cycle, queue never grows past one.
        prevReg = 0;
        prevDat = 0;
        for (int i = 0; i < 10; i++) begin
            logic [2:0] r;
            r = 3'((i % 7) + 1);
            drive(1, r, 32'h100 + 32'(i), 1, r, prevReg);
            #1;
            checkModel($sformatf("stream%0d", i));
            chk($sformatf("stream%0d_le1", i), 32'(bus.Count <= 1), 1);
            if (i > 0) begin
                chk($sformatf("stream%0d_lagreg", i), 32'(bus.WriteReg), 32'(prevReg));
                chk($sformatf("stream%0d_lagdat", i), bus.WriteData, prevDat);
            end
            prevReg = r;
            prevDat = 32'h100 + 32'(i);
            tick();
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom), $urandom,
                  1'($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom));
            #1;
            checkModel($sformatf("rnd%0d", i));
            tick();
        end

        // Async reset with entries pending.
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            tick();
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1, 3'(i), 32'h900 + 32'(i), 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 2, 3);
        #1;
        checkModel("prearst");
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("arst_count", 32'(bus.Count), 0);
        chk("arst_regwr", 32'(bus.RegWrite), 0);
        chk("arst_hit1", 32'(bus.Hit1), 0);
        chk("arst_hit2", 32'(bus.Hit2), 0);
        chk("arst_empty", 32'(bus.Empty), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkModel($sformatf("postrst%0d", i));
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
